// File: rtl/multi_channel_health_monitor_pkg.sv
// Shared blink FSM encoding and sizing helper for the multi-channel health monitor.
package multi_channel_health_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_PAUSE = 2'd3
  } blink_state_t;

  // Bits needed to hold 0..n-1, never fewer than one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_health_monitor_chan_filter.sv
// One sensor channel: multi-flop synchroniser followed by a saturating glitch counter.
module multi_channel_health_monitor_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int THRESHOLD   = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = $clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(THRESHOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (!synced)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // The current synced sample counts toward the run, so THRESHOLD highs trip.
  assign filt = synced && (cnt_q >= CNT_TRIP);

endmodule

// File: rtl/multi_channel_health_monitor.sv
// N-channel health monitor: filtered per-channel alarms, first-fault capture, relay/LEDs and blink code.
module multi_channel_health_monitor
  import multi_channel_health_monitor_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int THRESHOLD     = 50000,
  parameter int BLINK_LIMIT   = 2500000,
  parameter int PAUSE_PERIODS = 4,
  parameter int LATCH_MODE    = 1,
  localparam int CH_W         = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] Vout,
  input  logic              clear_alarm,
  output logic [NUM_CH-1:0] alarm_flags,
  output logic [CH_W-1:0]   first_fault,
  output logic              fault_valid,
  output logic              relay_output,
  output logic              red_led,
  output logic              green_led
);

  localparam int PAUSE_CYCLES = PAUSE_PERIODS * BLINK_LIMIT;
  localparam int TMR_W = clog2_min1((PAUSE_CYCLES > BLINK_LIMIT) ? PAUSE_CYCLES : BLINK_LIMIT);
  localparam logic [TMR_W-1:0] BLINK_END = TMR_W'(BLINK_LIMIT - 1);
  localparam logic [TMR_W-1:0] PAUSE_END = TMR_W'(PAUSE_CYCLES - 1);

  logic [NUM_CH-1:0] filt;
  logic [NUM_CH-1:0] flag_next;
  logic [CH_W-1:0]   lowest;
  blink_state_t      state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [CH_W-1:0]   pulse_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    multi_channel_health_monitor_chan_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .THRESHOLD  (THRESHOLD)
    ) u_filter (
      .clk  (clk),
      .reset(reset),
      .raw  (Vout[i]),
      .filt (filt[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    flag_next = filt;
    if (LATCH_MODE != 0)
      flag_next = filt | (alarm_flags & ~{NUM_CH{clear_alarm}});
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (flag_next[i]) lowest = CH_W'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_flags  <= '0;
      first_fault  <= '0;
      fault_valid  <= 1'b0;
      relay_output <= 1'b0;
      green_led    <= 1'b1;
    end else begin
      alarm_flags  <= flag_next;
      relay_output <= |alarm_flags;
      green_led    <= ~|alarm_flags;
      if (flag_next == '0) begin
        fault_valid <= 1'b0;
        first_fault <= '0;
      end else if (alarm_flags == '0) begin
        fault_valid <= 1'b1;
        first_fault <= lowest;
      end
    end
  end

  // Blink code: first_fault+1 pulses, then a long pause, repeated while any flag is up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      red_led <= 1'b0;
      timer_q <= '0;
      pulse_q <= '0;
    end else if (alarm_flags == '0) begin
      state_q <= ST_IDLE;
      red_led <= 1'b0;
      timer_q <= '0;
      pulse_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_ON;
          red_led <= 1'b1;
          timer_q <= '0;
          pulse_q <= '0;
        end
        ST_ON: begin
          if (timer_q == BLINK_END) begin
            state_q <= ST_OFF;
            red_led <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_OFF: begin
          if (timer_q == BLINK_END) begin
            timer_q <= '0;
            if (pulse_q == first_fault) begin
              state_q <= ST_PAUSE;
            end else begin
              pulse_q <= pulse_q + 1'b1;
              state_q <= ST_ON;
              red_led <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (timer_q == PAUSE_END) begin
            state_q <= ST_ON;
            red_led <= 1'b1;
            timer_q <= '0;
            pulse_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          red_led <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_health_monitor.sv
// Directed bench: latching and transparent monitors with small timing parameters.
module tb_multi_channel_health_monitor;

  logic       clk;
  logic       reset;
  logic       clear_alarm;
  logic [3:0] vout_a;
  logic [3:0] vout_b;

  logic [3:0] flags_a, flags_b;
  logic [1:0] ff_a, ff_b;
  logic       valid_a, valid_b;
  logic       relay_a, relay_b;
  logic       red_a, red_b;
  logic       green_a, green_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] red_seq;
  logic [39:0] red_exp;

  multi_channel_health_monitor #(
    .NUM_CH(4), .SYNC_STAGES(2), .THRESHOLD(10),
    .BLINK_LIMIT(2), .PAUSE_PERIODS(4), .LATCH_MODE(1)
  ) dut (
    .clk(clk), .reset(reset), .Vout(vout_a), .clear_alarm(clear_alarm),
    .alarm_flags(flags_a), .first_fault(ff_a), .fault_valid(valid_a),
    .relay_output(relay_a), .red_led(red_a), .green_led(green_a)
  );

  multi_channel_health_monitor #(
    .NUM_CH(4), .SYNC_STAGES(2), .THRESHOLD(10),
    .BLINK_LIMIT(2), .PAUSE_PERIODS(4), .LATCH_MODE(0)
  ) dut_transparent (
    .clk(clk), .reset(reset), .Vout(vout_b), .clear_alarm(clear_alarm),
    .alarm_flags(flags_b), .first_fault(ff_b), .fault_valid(valid_b),
    .relay_output(relay_b), .red_led(red_b), .green_led(green_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear_alarm = 1'b1;
    tick(1);
    clear_alarm = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    clear_alarm = 1'b0;
    vout_a      = '0;
    vout_b      = '0;
    #23;
    check("reset_flags", flags_a, 4'b0000);
    check("reset_ff", {valid_a, ff_a}, 3'b000);
    check("reset_leds", {relay_a, green_a, red_a}, 3'b010);
    reset = 1'b1;
    tick(2);

    // Short bursts (5 and THRESHOLD-1 cycles) must never trip.
    for (int b = 0; b < 2; b++) begin
      vout_a[0] = 1'b1;
      tick(b == 0 ? 5 : 9);
      vout_a[0] = 1'b0;
      for (int c = 0; c < 6; c++) begin
        check($sformatf("glitch%0d_c%0d", b, c), {flags_a, relay_a, green_a, red_a}, 7'b0000_010);
        tick(1);
      end
    end

    // Channel 2 trips after SYNC_STAGES+THRESHOLD = 12 cycles.
    vout_a[2] = 1'b1;
    tick(11);
    check("ch2_not_yet", flags_a, 4'b0000);
    tick(1);
    check("ch2_flags", flags_a, 4'b0100);
    check("ch2_ff", {valid_a, ff_a}, 3'b110);
    check("ch2_leds_lag", {relay_a, green_a}, 2'b01);
    for (int n = 0; n < 40; n++) begin
      tick(1);
      red_seq[n] = red_a;
      red_exp[n] = ((n % 20) < 12) && ((n % 4) < 2);
      if (n == 0) check("ch2_leds", {relay_a, green_a}, 2'b10);
    end
    check("ch2_blink_code", red_seq, red_exp);

    // Latched flag survives the input dropping; clear_alarm then releases it.
    vout_a[2] = 1'b0;
    tick(5);
    check("latch_hold", {flags_a, valid_a, ff_a}, 7'b0100_110);
    pulse_clear();
    check("clear_flags", {flags_a, valid_a, ff_a}, 7'b0000_000);
    tick(1);
    check("clear_leds", {relay_a, green_a, red_a}, 3'b010);

    // Simultaneous trip picks the lowest index; clear spares a still-high channel.
    vout_a[1] = 1'b1;
    vout_a[3] = 1'b1;
    tick(12);
    check("dual_flags", flags_a, 4'b1010);
    check("dual_ff", {valid_a, ff_a}, 3'b101);
    vout_a[1] = 1'b0;
    tick(4);
    pulse_clear();
    check("partial_clear_flags", flags_a, 4'b1000);
    check("partial_clear_ff", {valid_a, ff_a}, 3'b101);
    vout_a[3] = 1'b0;
    tick(4);
    pulse_clear();
    tick(1);
    check("dual_cleared", {flags_a, relay_a, green_a, red_a}, 7'b0000_010);

    // Transparent instance: flag follows the filter, clear_alarm has no effect.
    vout_b[0] = 1'b1;
    tick(11);
    check("tr_not_yet", flags_b, 4'b0000);
    tick(1);
    check("tr_rise", flags_b, 4'b0001);
    check("tr_ff", {valid_b, ff_b}, 3'b100);
    pulse_clear();
    check("tr_clear_ignored", flags_b, 4'b0001);
    check("tr_relay_on", relay_b, 1'b1);
    tick(2);
    vout_b[0] = 1'b0;
    tick(2);
    check("tr_still_high", flags_b, 4'b0001);
    tick(1);
    check("tr_fall", {flags_b, relay_b}, 5'b0000_1);
    tick(1);
    check("tr_relay_off", {relay_b, green_b, valid_b}, 3'b010);

    // Asynchronous reset in the middle of an ON pulse.
    vout_a[0] = 1'b1;
    tick(13);
    check("pre_reset_on", {flags_a, red_a}, 5'b0001_1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {flags_a, valid_a, ff_a, relay_a, green_a, red_a}, 10'b0000_000_010);
    vout_a[0] = 1'b0;
    #3;
    reset = 1'b1;
    tick(5);
    check("post_reset_idle", {flags_a, relay_a, green_a, red_a}, 7'b0000_010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
